if_stage: RTL and testbench

- Instruction-fetch stage of the five-stage pipelined MIPS core, directly upstream of the 1024-word instruction memory.
- Holds the PC and drives the memory word address.
- Selects the next PC from four sources: sequential, branch, jump, jump-register.
- Owns the IF/ID pipeline register, which captures the returned instruction and PC+4 for decode; hazard-unit stall and flush act on it.

---
 rtl/cpu_defs_pkg.sv | 23 ++
 rtl/npc_unit.sv | 41 ++++
 rtl/if_stage.sv | 80 ++++++++
 tb/tb_if_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// ============================================================================
//  Module : cpu_defs (package)
//  Brief  : Shared constants and next-PC select encodings for the MIPS core.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam logic [31:0] PC_BASE_DEF = 32'h0000_3000;
    localparam int          IMEM_WORDS  = 1024;
    localparam logic [31:0] NOP         = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

endpackage

`default_nettype wire

// File: rtl/npc_unit.sv
// ============================================================================
//  Module : npc_unit
//  Brief  : Next-PC target computation and 4:1 source select.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module npc_unit
    import cpu_defs::*;
(
    input  logic [1:0]  npc_sel,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc4_d,
    input  logic [15:0] imm16_d,
    input  logic [25:0] index_d,
    input  logic [31:0] rs_d,
    output logic [31:0] npc
);

    logic [31:0] w_seq;
    logic [31:0] w_branch;
    logic [31:0] w_jump;

    // Branch offsets are relative to the delay-slot address held in D.
    assign w_seq    = pc_f + 32'd4;
    assign w_branch = pc4_d + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    assign w_jump   = {pc4_d[31:28], index_d, 2'b00};

    always_comb begin
        npc = w_seq;
        case (npc_sel)
            NPC_SEQ: npc = w_seq;
            NPC_BR:  npc = w_branch;
            NPC_J:   npc = w_jump;
            NPC_JR:  npc = rs_d;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module : if_stage
//  Brief  : Instruction fetch: PC register, fetch-fault check, IF/ID register.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_BASE = PC_BASE_DEF,
    parameter int          IMEM_AW = $clog2(IMEM_WORDS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         npc_sel,
    input  logic [15:0]        imm16_d,
    input  logic [25:0]        index_d,
    input  logic [31:0]        rs_d,
    input  logic [31:0]        instr_i,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc_f,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc4_d,
    output logic               fault_d
);

    localparam logic [31:0] C_PC_LIMIT = PC_BASE + 32'(4 * (2 ** IMEM_AW));

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_fault;
    logic [31:0] w_npc;
    logic        w_fault;

    npc_unit u_npc (
        .npc_sel (npc_sel),
        .pc_f    (r_pc),
        .pc4_d   (r_pc4),
        .imm16_d (imm16_d),
        .index_d (index_d),
        .rs_d    (rs_d),
        .npc     (w_npc)
    );

    assign imem_addr = IMEM_AW'((r_pc - PC_BASE) >> 2);
    assign w_fault   = (r_pc[1:0] != 2'b00) || (r_pc < PC_BASE) || (r_pc >= C_PC_LIMIT);

    // A faulting fetch still follows the normal next-PC path so a redirect recovers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= PC_BASE;
            r_instr <= NOP;
            r_pc4   <= PC_BASE;
            r_fault <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_npc;
            if (flush) begin
                r_instr <= NOP;
                r_pc4   <= 32'h0;
                r_fault <= 1'b0;
            end else begin
                r_instr <= w_fault ? NOP : instr_i;
                r_pc4   <= r_pc + 32'd4;
                r_fault <= w_fault;
            end
        end
    end

    assign pc_f    = r_pc;
    assign instr_d = r_instr;
    assign pc4_d   = r_pc4;
    assign fault_d = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module : tb_if_stage
//  Brief  : Directed and randomized bench for if_stage against a fetch model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam logic [31:0] LIMIT = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic [15:0] imm16_d = 16'h0;
    logic [25:0] index_d = 26'h0;
    logic [31:0] rs_d = 32'h0;
    logic [31:0] instr_i;
    logic [9:0]  imem_addr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        fault_d;

    logic [31:0] mem [0:1023];
    assign instr_i = mem[imem_addr];

    // Reference state of the fetch stage, derived from architectural rules.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_fault;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(.PC_BASE(BASE), .IMEM_AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .npc_sel   (npc_sel),
        .imm16_d   (imm16_d),
        .index_d   (index_d),
        .rs_d      (rs_d),
        .instr_i   (instr_i),
        .imem_addr (imem_addr),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc4_d     (pc4_d),
        .fault_d   (fault_d)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = BASE; m_instr = 32'h0; m_pc4 = BASE; m_fault = 1'b0;
    endtask

    // Advance one clock; model computed from pre-edge inputs, outputs settle at +1.
    task automatic step();
        logic [31:0] tgt;
        logic        bad;
        int          word;
        case (npc_sel)
            2'd0:    tgt = m_pc + 4;
            2'd1:    tgt = m_pc4 + 32'($signed(imm16_d) * 4);
            2'd2:    tgt = (m_pc4 & 32'hF000_0000) | (32'(index_d) * 4);
            default: tgt = rs_d;
        endcase
        bad  = (m_pc % 4 != 0) || (m_pc < BASE) || (m_pc >= LIMIT);
        word = int'(((m_pc - BASE) / 4) % 1024);
        @(posedge clk);
        if (!stall) begin
            if (flush) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_fault = 1'b0;
            end else begin
                m_instr = bad ? 32'h0 : mem[word];
                m_pc4   = m_pc + 4;
                m_fault = bad;
            end
            m_pc = tgt;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        n_checks++; if (pc_f !== BASE) begin n_errors++; $display("FAIL reset_pc: got %h want %h", pc_f, BASE); end
        n_checks++; if (imem_addr !== 10'd0) begin n_errors++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
        n_checks++; if ({instr_d, pc4_d, fault_d} !== {32'h0, BASE, 1'b0}) begin
            n_errors++; $display("FAIL reset_ifid: got %h %h %b want 0 %h 0", instr_d, pc4_d, fault_d, BASE); end
    endtask

    task automatic test_sequential();
        npc_sel = 2'b00;
        step();
        n_checks++; if ({pc_f, imem_addr} !== {32'h3004, 10'd1}) begin n_errors++; $display("FAIL seq1_pc: got %h/%0d want 3004/1", pc_f, imem_addr); end
        n_checks++; if ({instr_d, pc4_d} !== {mem[0], 32'h3004}) begin n_errors++; $display("FAIL seq1_ifid: got %h %h want %h 3004", instr_d, pc4_d, mem[0]); end
        step();
        n_checks++; if ({pc_f, imem_addr} !== {32'h3008, 10'd2}) begin n_errors++; $display("FAIL seq2_pc: got %h/%0d want 3008/2", pc_f, imem_addr); end
        n_checks++; if ({instr_d, pc4_d} !== {mem[1], 32'h3008}) begin n_errors++; $display("FAIL seq2_ifid: got %h %h want %h 3008", instr_d, pc4_d, mem[1]); end
    endtask

    task automatic test_branch();
        npc_sel = 2'b01; imm16_d = 16'hFFFE;
        step();
        n_checks++; if (pc_f !== 32'h3000) begin n_errors++; $display("FAIL branch_pc: got %h want 3000", pc_f); end
        n_checks++; if ({instr_d, pc4_d} !== {mem[2], 32'h300C}) begin n_errors++; $display("FAIL branch_slot: got %h %h want %h 300c", instr_d, pc4_d, mem[2]); end
    endtask

    task automatic test_jump_jr();
        npc_sel = 2'b10; index_d = 26'h0000C10;
        step();
        n_checks++; if (pc_f !== 32'h3040) begin n_errors++; $display("FAIL jump_pc: got %h want 3040", pc_f); end
        npc_sel = 2'b11; rs_d = 32'h30FC;
        step();
        n_checks++; if ({pc_f, imem_addr} !== {32'h30FC, 10'd63}) begin n_errors++; $display("FAIL jr_pc: got %h/%0d want 30fc/63", pc_f, imem_addr); end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, in0, p40;
        pc0 = pc_f; in0 = instr_d; p40 = pc4_d;
        stall = 1'b1; npc_sel = 2'b01; imm16_d = 16'h0004;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if ({pc_f, instr_d, pc4_d} !== {pc0, in0, p40}) begin
                n_errors++; $display("FAIL stall_hold%0d: got %h %h %h want %h %h %h", i, pc_f, instr_d, pc4_d, pc0, in0, p40); end
        end
        stall = 1'b0;
        step();
        n_checks++; if (pc_f !== p40 + 32'd16) begin n_errors++; $display("FAIL stall_release: got %h want %h", pc_f, p40 + 32'd16); end
    endtask

    task automatic test_flush();
        logic [31:0] pc0;
        pc0 = pc_f; npc_sel = 2'b00; flush = 1'b1;
        step();
        n_checks++; if ({instr_d, pc4_d, fault_d, pc_f} !== {32'h0, 32'h0, 1'b0, pc0 + 32'd4}) begin
            n_errors++; $display("FAIL flush: got %h %h %b pc %h want 0 0 0 pc %h", instr_d, pc4_d, fault_d, pc_f, pc0 + 32'd4); end
        stall = 1'b1;
        step();
        n_checks++; if ({instr_d, pc4_d, fault_d, pc_f} !== {32'h0, 32'h0, 1'b0, pc0 + 32'd4}) begin
            n_errors++; $display("FAIL flush_stall: got %h %h %b pc %h want 0 0 0 pc %h", instr_d, pc4_d, fault_d, pc_f, pc0 + 32'd4); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_fault_and_async_reset();
        npc_sel = 2'b11; rs_d = 32'h3002;
        step();
        rs_d = 32'h4000;
        step();
        n_checks++; if ({instr_d, fault_d, pc_f} !== {32'h0, 1'b1, 32'h4000}) begin
            n_errors++; $display("FAIL fault_misalign: got %h %b pc %h want 0 1 pc 4000", instr_d, fault_d, pc_f); end
        npc_sel = 2'b00;
        step();
        n_checks++; if ({instr_d, fault_d, pc4_d} !== {32'h0, 1'b1, 32'h4004}) begin
            n_errors++; $display("FAIL fault_range: got %h %b %h want 0 1 4004", instr_d, fault_d, pc4_d); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({pc_f, instr_d, pc4_d, fault_d} !== {BASE, 32'h0, BASE, 1'b0}) begin
            n_errors++; $display("FAIL async_reset: got %h %h %h %b want %h 0 %h 0", pc_f, instr_d, pc4_d, fault_d, BASE, BASE); end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall   = ($urandom_range(0, 9) < 2);
            flush   = ($urandom_range(0, 9) < 1);
            npc_sel = 2'($urandom_range(0, 3));
            imm16_d = 16'($urandom);
            index_d = 26'($urandom_range(12'hC00, 12'hFFF));
            rs_d    = ($urandom_range(0, 9) < 8) ? BASE + 32'(4 * $urandom_range(0, 1023)) : $urandom;
            step();
            n_checks++; if ({pc_f, instr_d, pc4_d, fault_d} !== {m_pc, m_instr, m_pc4, m_fault}) begin
                n_errors++; $display("FAIL random%0d: got pc %h ins %h pc4 %h f %b want pc %h ins %h pc4 %h f %b",
                    i, pc_f, instr_d, pc4_d, fault_d, m_pc, m_instr, m_pc4, m_fault); end
            n_checks++; if (imem_addr !== 10'((m_pc - BASE) / 4)) begin
                n_errors++; $display("FAIL random_addr%0d: got %0d want %0d", i, imem_addr, 10'((m_pc - BASE) / 4)); end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_jump_jr();
        test_stall();
        test_flush();
        test_fault_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
